// File: rtl/game_pkg.sv
// Shared types and constants for the frame event tracker: player life-cycle states,
// default point/frame values, flag bit positions and a constant binary-to-BCD helper.
package game_pkg;

  typedef enum logic [1:0] {
    ALIVE     = 2'd0,
    DYING     = 2'd1,
    RESPAWN   = 2'd2,
    GAME_OVER = 2'd3
  } player_state_t;

  localparam int LIVES_INIT_DEF     = 3;
  localparam int DYING_FRAMES_DEF   = 30;
  localparam int RESPAWN_FRAMES_DEF = 60;
  localparam int SCORE_W_DEF        = 16;
  localparam int ALIEN_PTS_DEF      = 250;
  localparam int GOLD_PTS_DEF       = 500;

  localparam int FCNT_W = 8;

  localparam int NFLAGS    = 4;
  localparam int FLG_ALIEN = 0;
  localparam int FLG_GOLD  = 1;
  localparam int FLG_HIT   = 2;
  localparam int FLG_FIRE  = 3;

  // Elaboration-time conversion of point constants into packed BCD (16 digits).
  function automatic logic [63:0] bin_to_bcd(input int unsigned val);
    int unsigned v;
    logic [63:0] r;
    v = val;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/score_accum.sv
// Saturating score register. Binary add by default; packed-BCD add with digit-wise
// decimal carry when SCORE_BCD_EN is defined.
module score_accum
  import game_pkg::*;
#(
  parameter int SCORE_W   = SCORE_W_DEF,
  parameter int ALIEN_PTS = ALIEN_PTS_DEF,
  parameter int GOLD_PTS  = GOLD_PTS_DEF
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               add_alien_i,
  input  logic               add_gold_i,
  output logic [SCORE_W-1:0] score_o
);

  logic [SCORE_W-1:0] score_q, score_d;

`ifdef SCORE_BCD_EN
  localparam int NDIG = SCORE_W / 4;
  localparam logic [63:0] ALIEN_BCD = bin_to_bcd(ALIEN_PTS);
  localparam logic [63:0] GOLD_BCD  = bin_to_bcd(GOLD_PTS);
  localparam logic [63:0] BOTH_BCD  = bin_to_bcd(ALIEN_PTS + GOLD_PTS);

  logic [SCORE_W-1:0] delta;
  logic [SCORE_W-1:0] sum;
  logic [4:0]         dsum;
  logic               carry;

  always_comb begin
    delta = '0;
    case ({add_gold_i, add_alien_i})
      2'b01:   delta = ALIEN_BCD[SCORE_W-1:0];
      2'b10:   delta = GOLD_BCD[SCORE_W-1:0];
      2'b11:   delta = BOTH_BCD[SCORE_W-1:0];
      default: delta = '0;
    endcase
    sum   = '0;
    carry = 1'b0;
    dsum  = '0;
    for (int i = 0; i < NDIG; i++) begin
      dsum = {1'b0, score_q[4*i +: 4]} + {1'b0, delta[4*i +: 4]} + {4'd0, carry};
      if (dsum > 5'd9) begin
        dsum  = dsum - 5'd10;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      sum[4*i +: 4] = dsum[3:0];
    end
    score_d = score_q;
    if (add_alien_i || add_gold_i) begin
      score_d = carry ? {NDIG{4'h9}} : sum;
    end
  end
`else
  localparam int SUM_W = SCORE_W + 11;

  logic [SUM_W-1:0] delta;
  logic [SUM_W-1:0] sum;

  always_comb begin
    delta = '0;
    if (add_alien_i) delta = delta + SUM_W'(ALIEN_PTS);
    if (add_gold_i)  delta = delta + SUM_W'(GOLD_PTS);
    sum     = {11'd0, score_q} + delta;
    score_d = score_q;
    if (add_alien_i || add_gold_i) begin
      score_d = (sum > {11'd0, {SCORE_W{1'b1}}}) ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (resetN) score_q <= '0;
    else        score_q <= score_d;
  end

  assign score_o = score_q;

endmodule

// File: rtl/frame_event_tracker.sv
// Latches per-pixel collision flags over a frame, publishes them as 1-cycle pulses at the
// next startOfFrame, and runs score/lives/player FSM. Score format set by SCORE_BCD_EN.
//
// state     | meaning
// ALIVE     | player active, hits honoured, player_awake=1
// DYING     | death animation, counts DYING_FRAMES frames
// RESPAWN   | respawn delay, counts RESPAWN_FRAMES frames
// GAME_OVER | terminal until reset, all pulses and scoring suppressed
module frame_event_tracker
  import game_pkg::*;
#(
  parameter int LIVES_INIT     = LIVES_INIT_DEF,
  parameter int DYING_FRAMES   = DYING_FRAMES_DEF,
  parameter int RESPAWN_FRAMES = RESPAWN_FRAMES_DEF,
  parameter int SCORE_W        = SCORE_W_DEF,
  parameter int ALIEN_PTS      = ALIEN_PTS_DEF,
  parameter int GOLD_PTS       = GOLD_PTS_DEF
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               player_died,
  input  logic               alien_died_a,
  input  logic               player_eat_gold_1,
  input  logic               colision_fire,
  output logic               player_awake,
  output logic               player_hit_pulse,
  output logic               alien_kill_pulse,
  output logic               gold_taken_pulse,
  output logic               shot_done_pulse,
  output logic [2:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic               game_over
);

  player_state_t     state_q, state_d;
  logic [NFLAGS-1:0] sticky_q, sticky_d;
  logic [NFLAGS-1:0] pulse_q, pulse_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [2:0]        lives_q, lives_d;
  logic [NFLAGS-1:0] flags;

  assign flags = {colision_fire, player_died, player_eat_gold_1, alien_died_a};

  always_comb begin
    sticky_d = startOfFrame ? flags : (sticky_q | flags);
    pulse_d  = '0;
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    lives_d  = lives_q;
    if (startOfFrame && state_q != GAME_OVER) begin
      pulse_d = sticky_q;
      // A hit outside ALIVE is dropped together with its sticky bit.
      if (state_q != ALIVE) pulse_d[FLG_HIT] = 1'b0;
    end
    if (startOfFrame) begin
      case (state_q)
        ALIVE: begin
          if (pulse_d[FLG_HIT]) begin
            state_d = DYING;
            fcnt_d  = FCNT_W'(DYING_FRAMES - 1);
            lives_d = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
          end
        end
        DYING: begin
          if (fcnt_q == '0) begin
            state_d = (lives_q == 3'd0) ? GAME_OVER : RESPAWN;
            fcnt_d  = FCNT_W'(RESPAWN_FRAMES - 1);
          end else begin
            fcnt_d = fcnt_q - 1'b1;
          end
        end
        RESPAWN: begin
          if (fcnt_q == '0) state_d = ALIVE;
          else              fcnt_d  = fcnt_q - 1'b1;
        end
        default: state_d = GAME_OVER;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (resetN) begin
      state_q  <= ALIVE;
      sticky_q <= '0;
      pulse_q  <= '0;
      fcnt_q   <= '0;
      lives_q  <= 3'(LIVES_INIT);
    end else begin
      state_q  <= state_d;
      sticky_q <= sticky_d;
      pulse_q  <= pulse_d;
      fcnt_q   <= fcnt_d;
      lives_q  <= lives_d;
    end
  end

  score_accum #(
    .SCORE_W  (SCORE_W),
    .ALIEN_PTS(ALIEN_PTS),
    .GOLD_PTS (GOLD_PTS)
  ) u_score (
    .clk        (clk),
    .resetN     (resetN),
    .add_alien_i(pulse_d[FLG_ALIEN]),
    .add_gold_i (pulse_d[FLG_GOLD]),
    .score_o    (score)
  );

  assign player_awake     = (state_q == ALIVE);
  assign game_over        = (state_q == GAME_OVER);
  assign alien_kill_pulse = pulse_q[FLG_ALIEN];
  assign gold_taken_pulse = pulse_q[FLG_GOLD];
  assign player_hit_pulse = pulse_q[FLG_HIT];
  assign shot_done_pulse  = pulse_q[FLG_FIRE];
  assign lives            = lives_q;

endmodule

// File: tb/tb_frame_event_tracker.sv
// Self-checking bench for frame_event_tracker: directed scenarios plus random frames,
// checked against a frame-level reference model of scoring, lives and player life cycle.
module tb_frame_event_tracker;

  localparam int SCORE_W = 16;
  localparam int DYING_F = 30;
  localparam int RESP_F  = 60;
`ifdef SCORE_BCD_EN
  localparam int SMAX = 9999;
`else
  localparam int SMAX = 65535;
`endif

  logic clk = 1'b0;
  logic resetN, startOfFrame, player_died, alien_died_a, player_eat_gold_1, colision_fire;
  logic player_awake, player_hit_pulse, alien_kill_pulse, gold_taken_pulse, shot_done_pulse;
  logic [2:0] lives;
  logic [SCORE_W-1:0] score;
  logic game_over;

  always #5 clk = ~clk;

  frame_event_tracker dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .player_died(player_died), .alien_died_a(alien_died_a),
    .player_eat_gold_1(player_eat_gold_1), .colision_fire(colision_fire),
    .player_awake(player_awake), .player_hit_pulse(player_hit_pulse),
    .alien_kill_pulse(alien_kill_pulse), .gold_taken_pulse(gold_taken_pulse),
    .shot_done_pulse(shot_done_pulse), .lives(lives), .score(score), .game_over(game_over)
  );

  int n_cmp = 0;
  int n_err = 0;

  // model: player status 0=alive 1=dying 2=respawn 3=over, frames left in current phase
  int m_status, m_left, m_lives, m_score;
  logic [3:0] m_pend;
  // expected values after the last frame boundary
  logic [3:0] e_pulses;
  logic [2:0] e_lives;
  logic [SCORE_W-1:0] e_score;
  logic e_awake, e_go;
  // observations: at T+1 and pulses at T+2
  logic [3:0] o_pulses, o2_pulses;
  logic [2:0] o_lives;
  logic [SCORE_W-1:0] o_score;
  logic o_awake, o_go;

  function automatic logic [SCORE_W-1:0] score_out(input int s);
`ifdef SCORE_BCD_EN
    logic [SCORE_W-1:0] r;
    int v;
    v = s;
    r = '0;
    for (int i = 0; i < SCORE_W / 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
`else
    return SCORE_W'(s);
`endif
  endfunction

  // flag order {fire, hit, gold, alien}
  task automatic drive(input logic [3:0] f);
    alien_died_a      = f[0];
    player_eat_gold_1 = f[1];
    player_died       = f[2];
    colision_fire     = f[3];
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    m_status = 0; m_left = 0; m_lives = 3; m_score = 0; m_pend = '0;
    e_pulses = '0; e_lives = 3'd3; e_score = '0; e_awake = 1'b1; e_go = 1'b0;
  endtask

  task automatic model_sof;
    logic [3:0] p;
    p = m_pend;
    e_pulses = '0;
    if (m_status != 3) begin
      e_pulses = p;
      if (m_status != 0) e_pulses[2] = 1'b0;
      m_score = m_score + (p[0] ? 250 : 0) + (p[1] ? 500 : 0);
      if (m_score > SMAX) m_score = SMAX;
    end
    if (m_status == 0) begin
      if (e_pulses[2]) begin
        m_lives  = (m_lives > 0) ? m_lives - 1 : 0;
        m_status = 1;
        m_left   = DYING_F;
      end
    end else if (m_status == 1) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_status = (m_lives == 0) ? 3 : 2;
        m_left   = RESP_F;
      end
    end else if (m_status == 2) begin
      m_left = m_left - 1;
      if (m_left == 0) m_status = 0;
    end
    e_lives = 3'(m_lives);
    e_score = score_out(m_score);
    e_awake = (m_status == 0);
    e_go    = (m_status == 3);
  endtask

  task automatic sample;
    o_pulses = {shot_done_pulse, player_hit_pulse, gold_taken_pulse, alien_kill_pulse};
    o_lives  = lives;
    o_score  = score;
    o_awake  = player_awake;
    o_go     = game_over;
  endtask

  task automatic do_reset;
    resetN = 1'b1; startOfFrame = 1'b0; drive(4'b0);
    tick; tick;
    resetN = 1'b0;
    model_reset();
    sample();
  endtask

  // body flags held for len cycles, then a startOfFrame cycle carrying at_sof flags
  task automatic run_frame(input logic [3:0] body, input logic [3:0] at_sof, input int len);
    for (int c = 0; c < len; c++) begin
      drive(body);
      tick;
    end
    m_pend = m_pend | body;
    drive(at_sof);
    startOfFrame = 1'b1;
    tick;
    sample();
    model_sof();
    m_pend = at_sof;
    startOfFrame = 1'b0;
    drive(4'b0);
    tick;
    o2_pulses = {shot_done_pulse, player_hit_pulse, gold_taken_pulse, alien_kill_pulse};
  endtask

  task automatic test_reset;
    do_reset();
    n_cmp++; if (o_pulses !== 4'b0) begin n_err++; $display("FAIL reset_pulses: got %b exp 0000", o_pulses); end
    n_cmp++; if (o_lives !== 3'd3) begin n_err++; $display("FAIL reset_lives: got %0d exp 3", o_lives); end
    n_cmp++; if (o_score !== '0) begin n_err++; $display("FAIL reset_score: got %h exp 0", o_score); end
    n_cmp++; if (o_awake !== 1'b1) begin n_err++; $display("FAIL reset_awake: got %b exp 1", o_awake); end
    n_cmp++; if (o_go !== 1'b0) begin n_err++; $display("FAIL reset_game_over: got %b exp 0", o_go); end
  endtask

  task automatic test_alien_pulse;
    run_frame(4'b0001, 4'b0000, 5);
    n_cmp++; if (o_pulses !== 4'b0001 || o_pulses !== e_pulses) begin n_err++; $display("FAIL alien_pulse: got %b exp %b", o_pulses, e_pulses); end
    n_cmp++; if (o_score !== e_score) begin n_err++; $display("FAIL alien_score: got %h exp %h", o_score, e_score); end
    n_cmp++; if (o2_pulses !== 4'b0) begin n_err++; $display("FAIL alien_pulse_width: got %b exp 0000", o2_pulses); end
  endtask

  task automatic test_flag_at_sof;
    run_frame(4'b0000, 4'b0001, 3);
    n_cmp++; if (o_pulses !== 4'b0000) begin n_err++; $display("FAIL sof_flag_early: got %b exp 0000", o_pulses); end
    run_frame(4'b0000, 4'b0000, 3);
    n_cmp++; if (o_pulses !== e_pulses || e_pulses !== 4'b0001) begin n_err++; $display("FAIL sof_flag_late: got %b exp %b", o_pulses, e_pulses); end
    n_cmp++; if (o_score !== e_score) begin n_err++; $display("FAIL sof_flag_score: got %h exp %h", o_score, e_score); end
  endtask

  task automatic test_hit_respawn;
    run_frame(4'b0100, 4'b0000, 3);
    n_cmp++; if (o_pulses !== 4'b0100) begin n_err++; $display("FAIL hit_pulse: got %b exp 0100", o_pulses); end
    n_cmp++; if (o_lives !== 3'd2) begin n_err++; $display("FAIL hit_lives: got %0d exp 2", o_lives); end
    n_cmp++; if (o_awake !== 1'b0) begin n_err++; $display("FAIL hit_awake: got %b exp 0", o_awake); end
    run_frame(4'b0100, 4'b0000, 3);
    n_cmp++; if (o_pulses !== 4'b0000) begin n_err++; $display("FAIL dying_hit_pulse: got %b exp 0000", o_pulses); end
    n_cmp++; if (o_lives !== 3'd2) begin n_err++; $display("FAIL dying_hit_lives: got %0d exp 2", o_lives); end
    for (int f = 0; f < DYING_F + RESP_F - 1; f++) begin
      run_frame(4'b0000, 4'b0000, 2);
      n_cmp++; if (o_awake !== e_awake) begin n_err++; $display("FAIL respawn_awake f%0d: got %b exp %b", f, o_awake, e_awake); end
    end
    n_cmp++; if (o_awake !== 1'b1) begin n_err++; $display("FAIL respawn_alive: got %b exp 1", o_awake); end
  endtask

  task automatic test_combo;
    run_frame(4'b0111, 4'b0000, 2);
    n_cmp++; if (o_pulses !== 4'b0111) begin n_err++; $display("FAIL combo_pulses: got %b exp 0111", o_pulses); end
    n_cmp++; if (o_score !== e_score) begin n_err++; $display("FAIL combo_score: got %h exp %h", o_score, e_score); end
    n_cmp++; if (o_lives !== e_lives) begin n_err++; $display("FAIL combo_lives: got %0d exp %0d", o_lives, e_lives); end
  endtask

  task automatic test_game_over;
    int guard;
    guard = 0;
    while (m_status != 3 && guard < 400) begin
      run_frame((m_status == 0) ? 4'b0100 : 4'b0000, 4'b0000, 2);
      guard++;
      n_cmp++; if (o_lives !== e_lives || o_go !== e_go || o_awake !== e_awake) begin
        n_err++; $display("FAIL gameover_path f%0d: got lives %0d go %b awake %b exp %0d %b %b", guard, o_lives, o_go, o_awake, e_lives, e_go, e_awake);
      end
    end
    n_cmp++; if (o_go !== 1'b1 || o_lives !== 3'd0) begin n_err++; $display("FAIL gameover_reached: got go %b lives %0d exp 1 0", o_go, o_lives); end
    for (int f = 0; f < 3; f++) begin
      run_frame(4'b1111, 4'b0000, 2);
      n_cmp++; if (o_pulses !== 4'b0000) begin n_err++; $display("FAIL gameover_pulses: got %b exp 0000", o_pulses); end
      n_cmp++; if (o_score !== e_score) begin n_err++; $display("FAIL gameover_score: got %h exp %h", o_score, e_score); end
    end
  endtask

  task automatic test_reset_mid;
    drive(4'b0011);
    tick;
    do_reset();
    n_cmp++; if (o_go !== 1'b0 || o_lives !== 3'd3 || o_awake !== 1'b1 || o_score !== '0) begin
      n_err++; $display("FAIL reset_mid: got go %b lives %0d awake %b score %h exp 0 3 1 0", o_go, o_lives, o_awake, o_score);
    end
    run_frame(4'b0000, 4'b0000, 2);
    n_cmp++; if (o_pulses !== 4'b0000) begin n_err++; $display("FAIL reset_mid_sticky: got %b exp 0000", o_pulses); end
  endtask

  task automatic test_saturation;
    do_reset();
    for (int f = 0; f < 87; f++) run_frame(4'b0011, 4'b0000, 1);
    run_frame(4'b0001, 4'b0000, 1);
    n_cmp++; if (o_score !== e_score) begin n_err++; $display("FAIL sat_preload: got %h exp %h", o_score, e_score); end
    run_frame(4'b0010, 4'b0000, 1);
    n_cmp++; if (o_score !== e_score || o_score !== score_out(SMAX)) begin n_err++; $display("FAIL sat_gold: got %h exp %h", o_score, e_score); end
    run_frame(4'b0001, 4'b0000, 1);
    n_cmp++; if (o_score !== score_out(SMAX)) begin n_err++; $display("FAIL sat_hold: got %h exp %h", o_score, score_out(SMAX)); end
  endtask

  task automatic test_random;
    logic [3:0] body, at_sof;
    do_reset();
    for (int f = 0; f < 300; f++) begin
      body = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) != 0) body[2] = 1'b0;
      at_sof = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 11)) : 4'b0;
      run_frame(body, at_sof, $urandom_range(1, 6));
      n_cmp++; if (o_pulses !== e_pulses || o2_pulses !== 4'b0) begin n_err++; $display("FAIL rand_pulses f%0d: got %b/%b exp %b/0000", f, o_pulses, o2_pulses, e_pulses); end
      n_cmp++; if (o_score !== e_score) begin n_err++; $display("FAIL rand_score f%0d: got %h exp %h", f, o_score, e_score); end
      n_cmp++; if (o_lives !== e_lives || o_awake !== e_awake || o_go !== e_go) begin
        n_err++; $display("FAIL rand_state f%0d: got lives %0d awake %b go %b exp %0d %b %b", f, o_lives, o_awake, o_go, e_lives, e_awake, e_go);
      end
    end
  endtask

  initial begin
    resetN = 1'b1; startOfFrame = 1'b0; drive(4'b0);
    test_reset();
    test_alien_pulse();
    test_flag_at_sof();
    test_hit_respawn();
    test_combo();
    test_game_over();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
